// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator.
// Divides clk down to the pixel rate, walks an h/v counter pair through the
// frame and emits registered vid_on / hsync / vsync / frame_start that always
// describe the position currently shown on pixel_x / pixel_y.
// Optional build macro: VGA_SYNC_DELAY_EN -- adds one pix_tick-enabled
// register stage on hsync/vsync so they line up with the painter's registered
// colour output (one pixel period behind the coordinates).
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       vid_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  // A 1-bit divider is kept even for CLK_DIV=1; it then never leaves 0,
  // which makes pix_tick permanently high.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             hsync_q;
  logic             vsync_q;

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  assign pix_tick = (div_cnt == DIV_LAST);

  // Position the counters move to on the next pix_tick edge.
  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Counters and decodes are registered together from the next position so
  // the qualifiers never skew against the coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      vid_on      <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      frame_start <= 1'b0;
    end else if (pix_tick) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      vid_on      <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hsync_q     <= !((h_nxt >= H_SYNC_ON) && (h_nxt < H_SYNC_OFF));
      vsync_q     <= !((v_nxt >= V_SYNC_ON) && (v_nxt < V_SYNC_OFF));
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_d;
  logic vsync_d;

  // Extra sync stage: lags the coordinates by exactly one pixel period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
    end else if (pix_tick) begin
      hsync_d <= hsync_q;
      vsync_d <= vsync_q;
    end
  end

  assign hsync = hsync_d;
  assign vsync = vsync_d;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 with /4, a small
// frame with /3, a tiny frame with /1) share clk and rst. A position model
// derived from "pixel boundaries elapsed since reset release" predicts every
// output each cycle; a vector table and a few hand sequences pin the corners.
module tb_vga_timing_gen;

  typedef struct {
    int x;
    int y;
    bit vid;
    bit hs;
    bit vs;
    bit fs;
    bit tick;
  } out_t;

  typedef struct {
    int k;
    int x;
    int y;
    bit vid;
    bit hs;
    bit hs_dly;
    bit fs;
    bit tick;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int kcnt     = 0;
  bit chk_en   = 1'b0;
  int hs_low_a = 0;
  int fs_clk_b = 0;

  logic       tick_a, vid_a, hs_a, vs_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       tick_b, vid_b, hs_b, vs_b, fs_b;
  logic [9:0] x_b, y_b;
  logic       tick_c, vid_c, hs_c, vs_c, fs_c;
  logic [9:0] x_c, y_c;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_tick(tick_a), .pixel_x(x_a), .pixel_y(y_a),
    .vid_on(vid_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_tick(tick_b), .pixel_x(x_b), .pixel_y(y_b),
    .vid_on(vid_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_c (
    .clk(clk), .rst(rst), .pix_tick(tick_c), .pixel_x(x_c), .pixel_y(y_c),
    .vid_on(vid_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; held at 0 while in reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) kcnt <= 0;
    else      kcnt <= kcnt + 1;
  end

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d k=%0d t=%0t", nm, got, exp, kcnt, $time);
    end
  endtask

  function automatic bit in_sync(int p, int start, int w);
    return (p >= start) && (p < start + w);
  endfunction

  // After k edges, a = k/div pixel boundaries have passed; the first one
  // lands on (0,0), so the raster index is a-1 modulo the frame size.
  function automatic out_t model(int k, int div, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb);
    out_t m;
    int ht, vt, a, l, p;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    a  = k / div;
    m.tick = ((k % div) == (div - 1));
    if (a == 0) begin
      m.x = ht - 1; m.y = vt - 1;
      m.vid = 1'b0; m.hs = 1'b1; m.vs = 1'b1; m.fs = 1'b0;
    end else begin
      l   = (a - 1) % (ht * vt);
      m.x = l % ht;
      m.y = l / ht;
      m.vid = (m.x < ha) && (m.y < va);
      m.fs  = (l == 0);
      m.hs  = !in_sync(m.x, ha + hf, hsw);
      m.vs  = !in_sync(m.y, va + vf, vsw);
`ifdef VGA_SYNC_DELAY_EN
      if (a == 1) begin
        m.hs = 1'b1; m.vs = 1'b1;
      end else begin
        p    = (a - 2) % (ht * vt);
        m.hs = !in_sync(p % ht, ha + hf, hsw);
        m.vs = !in_sync(p / ht, va + vf, vsw);
      end
`endif
    end
    return m;
  endfunction

  task automatic chk_inst(input string tag, input out_t m, input logic [9:0] x,
                          input logic [9:0] y, input logic vid, input logic hs,
                          input logic vs, input logic fs, input logic tick);
    cmp({tag, "_pixel_x"},     32'(x),    32'(m.x));
    cmp({tag, "_pixel_y"},     32'(y),    32'(m.y));
    cmp({tag, "_vid_on"},      32'(vid),  32'(m.vid));
    cmp({tag, "_hsync"},       32'(hs),   32'(m.hs));
    cmp({tag, "_vsync"},       32'(vs),   32'(m.vs));
    cmp({tag, "_frame_start"}, 32'(fs),   32'(m.fs));
    cmp({tag, "_pix_tick"},    32'(tick), 32'(m.tick));
  endtask

  task automatic chk_all(input string tag);
    chk_inst({tag, "_a"}, model(kcnt, 4, 640, 16, 96, 48, 480, 10, 2, 33),
             x_a, y_a, vid_a, hs_a, vs_a, fs_a, tick_a);
    chk_inst({tag, "_b"}, model(kcnt, 3, 20, 3, 4, 5, 12, 2, 2, 3),
             x_b, y_b, vid_b, hs_b, vs_b, fs_b, tick_b);
    chk_inst({tag, "_c"}, model(kcnt, 1, 6, 1, 2, 1, 4, 1, 1, 1),
             x_c, y_c, vid_c, hs_c, vs_c, fs_c, tick_c);
  endtask

  // Every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) chk_all("run");
    if (rst && kcnt >= 4 && kcnt < 3204 && hs_a === 1'b0) hs_low_a++;
    if (rst && kcnt >= 3 && kcnt < 3 + 5 * 1824 && fs_b === 1'b1) fs_clk_b++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t tbl[16];

  initial begin
    int guard;
    bit hs_exp;

    // k | x | y | vid | hs | hs (delayed build) | frame_start | pix_tick
    tbl[0]  = '{0,     799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{3,     799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{4,     0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{7,     0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{8,     1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{2560,  639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{2564,  640, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{2628,  656, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2632,  657, 0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3008,  751, 0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{3012,  752, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3016,  753, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{3200,  799, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{3204,  0,   1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{35200, 799, 10,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{35204, 0,   11,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    #2 rst = 1'b0;
    #1 chk_en = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      guard = 0;
      while (kcnt < tbl[i].k && guard < 60000) begin
        @(negedge clk);
        guard++;
      end
      cmp($sformatf("tbl%0d_reached", i), 32'(kcnt), 32'(tbl[i].k));
`ifdef VGA_SYNC_DELAY_EN
      hs_exp = tbl[i].hs_dly;
`else
      hs_exp = tbl[i].hs;
`endif
      cmp($sformatf("tbl%0d_pixel_x", i),     32'(x_a),    32'(tbl[i].x));
      cmp($sformatf("tbl%0d_pixel_y", i),     32'(y_a),    32'(tbl[i].y));
      cmp($sformatf("tbl%0d_vid_on", i),      32'(vid_a),  32'(tbl[i].vid));
      cmp($sformatf("tbl%0d_hsync", i),       32'(hs_a),   32'(hs_exp));
      cmp($sformatf("tbl%0d_vsync", i),       32'(vs_a),   32'(1));
      cmp($sformatf("tbl%0d_frame_start", i), 32'(fs_a),   32'(tbl[i].fs));
      cmp($sformatf("tbl%0d_pix_tick", i),    32'(tick_a), 32'(tbl[i].tick));
      if (i == 13) cmp("hsync_low_clocks", 32'(hs_low_a), 32'd384);
    end

    // Five frames of the small instance: five frame_start pulses of 3 clocks.
    cmp("frame_start_clocks_b", 32'(fs_clk_b), 32'd15);

    // Mid-pixel asynchronous reset: outputs must drop before any clock edge.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    cmp("async_pixel_x", 32'(x_a), 32'd799);
    cmp("async_pixel_y", 32'(y_a), 32'd524);
    cmp("async_vid_on",  32'(vid_a), 32'd0);
    cmp("async_hsync",   32'(hs_a), 32'd1);
    cmp("async_vsync",   32'(vs_a), 32'd1);
    cmp("async_fs",      32'(fs_a), 32'd0);
    cmp("async_tick",    32'(tick_a), 32'd0);
    cmp("async_tick_c",  32'(tick_c), 32'd1);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;

    // Restart timing after release matches the first bring-up.
    guard = 0;
    while (kcnt < 4 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cmp("restart_pixel_x", 32'(x_a), 32'd0);
    cmp("restart_pixel_y", 32'(y_a), 32'd0);
    cmp("restart_fs",      32'(fs_a), 32'd1);
    cmp("restart_vid_on",  32'(vid_a), 32'd1);

    // Random run lengths and reset phases; the per-cycle model checks all.
    repeat (6) begin
      repeat ($urandom_range(4000, 20)) @(negedge clk);
      #($urandom_range(4, 1)) rst = 1'b0;
      #1 chk_all("rnd_async");
      repeat ($urandom_range(4, 1)) @(negedge clk);
      #($urandom_range(4, 1)) rst = 1'b1;
    end
    repeat (2000) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
